// File: rtl/sram22_rr_port_ctrl_pkg.sv
// Shared types and constants for the sram22 round-robin port controller.
//   ctrl_state_e : controller FSM states (BOOT, INIT, RUN)
//   DEPTH        : word count of the default-sized macro (1 << ADDR_WIDTH)
package sram22_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } ctrl_state_e;

  localparam int ADDR_WIDTH = 6;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

endpackage

// File: rtl/sram22_rr_arb.sv
// Combinational round-robin arbiter.
//   req_i   : request vector, one bit per requester
//   ptr_i   : highest-priority requester index for this cycle
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : index of the granted requester (0 when no request)
//   any_o   : at least one request is being granted
module sram22_rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int cand;
    cand    = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    // Walk offsets from farthest to nearest so the requester closest to
    // ptr_i (in modulo order) is the last one written and therefore wins.
    for (int off = N - 1; off >= 0; off--) begin
      cand = (int'(ptr_i) + off) % N;
      if (req_i[cand]) begin
        idx_o = IW'(cand);
        any_o = 1'b1;
      end
    end
    if (any_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/sram22_rr_port_ctrl.sv
// Shares one single-port sram22 macro between NUM_REQ valid/ready requesters
// with round-robin arbitration, zero-fills the array after reset and returns
// read data one cycle after the read is accepted.
//   clk, rst                : clock and asynchronous active-high reset
//   req_valid/we/wmask/addr/din : packed per-requester request fields
//   req_ready               : one-hot acceptance strobe
//   rsp_valid, rsp_rdata    : per-requester read-data strobe, shared data bus
//   init_done               : array has been zero-filled
//   sram_we/wmask/addr/din  : macro input pins, sram_dout : macro output pin
module sram22_rr_port_ctrl
  import sram22_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 24,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 1,
  parameter bit INIT_EN     = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*WMASK_WIDTH-1:0] req_wmask,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_din,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           init_done,
  output logic                           sram_we,
  output logic [WMASK_WIDTH-1:0]         sram_wmask,
  output logic [ADDR_WIDTH-1:0]          sram_addr,
  output logic [DATA_WIDTH-1:0]          sram_din,
  input  logic [DATA_WIDTH-1:0]          sram_dout
);

  localparam int IW = $clog2(NUM_REQ);

  logic [WMASK_WIDTH-1:0] wmask_a [NUM_REQ];
  logic [ADDR_WIDTH-1:0]  addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  din_a   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign wmask_a[gi] = req_wmask[gi*WMASK_WIDTH +: WMASK_WIDTH];
    assign addr_a[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign din_a[gi]   = req_din[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  ctrl_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]  init_cnt_q, init_cnt_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [IW-1:0]          rd_id_q, rd_id_d;
  logic                   init_done_q, init_done_d;
  // Last values driven onto the macro, so the pins hold steady when idle.
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  logic [WMASK_WIDTH-1:0] wmask_q, wmask_d;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;

  sram22_rr_arb #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt_oh),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      rd_pend_q   <= 1'b0;
      rd_id_q     <= '0;
      init_done_q <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      wmask_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_pend_q   <= rd_pend_d;
      rd_id_q     <= rd_id_d;
      init_done_q <= init_done_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      wmask_q     <= wmask_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rd_pend_d   = 1'b0;
    rd_id_d     = rd_id_q;
    init_done_d = init_done_q;
    addr_d      = addr_q;
    din_d       = din_q;
    wmask_d     = wmask_q;
    req_ready   = '0;
    sram_we     = 1'b0;
    sram_wmask  = wmask_q;
    sram_addr   = addr_q;
    sram_din    = din_q;
    unique case (state_q)
      BOOT: begin
        if (INIT_EN) begin
          state_d = INIT;
        end else begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      INIT: begin
        sram_we    = 1'b1;
        sram_wmask = '1;
        sram_addr  = init_cnt_q;
        sram_din   = '0;
        wmask_d    = '1;
        addr_d     = init_cnt_q;
        din_d      = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        // All-ones counter value is the last word (DEPTH-1).
        if (&init_cnt_q) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (gnt_any) begin
          req_ready  = gnt_oh;
          sram_we    = req_we[gnt_idx];
          sram_wmask = wmask_a[gnt_idx];
          sram_addr  = addr_a[gnt_idx];
          sram_din   = din_a[gnt_idx];
          wmask_d    = wmask_a[gnt_idx];
          addr_d     = addr_a[gnt_idx];
          din_d      = din_a[gnt_idx];
          rr_ptr_d   = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          rd_pend_d  = ~req_we[gnt_idx];
          rd_id_d    = gnt_idx;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = rd_pend_q && (rd_id_q == IW'(gi));
  end

  // Macro output is already registered; it lines up with rd_pend_q.
  assign rsp_rdata = sram_dout;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram22_rr_port_ctrl.sv
module tb_sram22_rr_port_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [1:0]  req_wmask;
  logic [11:0] req_addr;
  logic [47:0] req_din;
  logic [1:0]  rsp_valid;
  logic [23:0] rsp_rdata;
  logic        init_done;
  logic        sram_we;
  logic [0:0]  sram_wmask;
  logic [5:0]  sram_addr;
  logic [23:0] sram_din;
  logic [23:0] sram_dout;

  int checks   = 0;
  int failures = 0;

  sram22_rr_port_ctrl #(
    .NUM_REQ     (2),
    .DATA_WIDTH  (24),
    .ADDR_WIDTH  (6),
    .WMASK_WIDTH (1),
    .INIT_EN     (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_din    (req_din),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .init_done  (init_done),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Behavioural single-port macro with registered read.
  logic [23:0] mem [64];
  always @(posedge clk) begin
    if (sram_we) begin
      if (sram_wmask[0]) mem[sram_addr] <= sram_din;
    end else begin
      sram_dout <= mem[sram_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [5:0] a, input logic [23:0] d);
    req_we[i]          = we;
    req_wmask[i]       = 1'b1;
    req_addr[i*6 +: 6] = a;
    req_din[i*24 +: 24] = d;
    $display("txn req%0d we=%0d addr=%0h din=%0h", i, we, a, d);
  endtask

  // Called just after rst falls (BOOT cycle). Checks BOOT, then INIT writes 0..last_k.
  task automatic run_init(input int last_k);
    set_req(0, 1'b0, 6'd7, 24'd0);
    set_req(1, 1'b0, 6'd9, 24'd0);
    req_valid = 2'b11;
    #1;
    chk("boot_we", sram_we, 0);
    chk("boot_ready", req_ready, 0);
    chk("boot_done", init_done, 0);
    for (int k = 0; k <= last_k; k++) begin
      @(posedge clk); #1;
      chk("init_we", sram_we, 1);
      chk("init_addr", sram_addr, k);
      chk("init_din", sram_din, 0);
      chk("init_wmask", sram_wmask, 1);
      chk("init_ready", req_ready, 0);
      chk("init_done_low", init_done, 0);
      if (k == 63) req_valid = 2'b00;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_wmask = '0; req_addr = '0; req_din = '0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_done", init_done, 0);
    chk("rst_we", sram_we, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Zero-fill: 64 writes then init_done.
    run_init(63);
    @(posedge clk); #1;
    chk("init_done_rise", init_done, 1);
    chk("run_idle_we", sram_we, 0);
    chk("run_idle_ready", req_ready, 0);

    // Write then read-after-write on requester 0.
    set_req(0, 1'b1, 6'd5, 24'hABCDEF); req_valid = 2'b01; #1;
    chk("w5_ready", req_ready, 2'b01);
    chk("w5_we", sram_we, 1);
    chk("w5_addr", sram_addr, 5);
    chk("w5_din", sram_din, 24'hABCDEF);
    @(posedge clk); #1;
    set_req(0, 1'b0, 6'd5, 24'd0); #1;
    chk("r5_ready", req_ready, 2'b01);
    chk("r5_we", sram_we, 0);
    chk("r5_addr", sram_addr, 5);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("r5_rsp", rsp_valid, 2'b01);
    chk("r5_data", rsp_rdata, 24'hABCDEF);

    // Requester 1 writes addr 2 (also moves rr_ptr back to 0).
    set_req(1, 1'b1, 6'd2, 24'h123456); req_valid = 2'b10; #1;
    chk("w2_ready", req_ready, 2'b10);
    chk("w2_din", sram_din, 24'h123456);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("w2_no_rsp", rsp_valid, 0);

    // Contention: both read every cycle, strict alternation.
    set_req(0, 1'b0, 6'd1, 24'd0);
    set_req(1, 1'b0, 6'd2, 24'd0);
    req_valid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_ready", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_addr", sram_addr, (c % 2 == 0) ? 1 : 2);
      if (c > 0) begin
        chk("rr_rsp", rsp_valid, (c % 2 == 1) ? 2'b01 : 2'b10);
        chk("rr_data", rsp_rdata, (c % 2 == 1) ? 24'h0 : 24'h123456);
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00; #1;
    chk("rr_last_rsp", rsp_valid, 2'b10);
    chk("rr_last_data", rsp_rdata, 24'h123456);
    chk("idle_we", sram_we, 0);
    chk("idle_addr_hold", sram_addr, 2);

    // Only req1, then both twice: 1, 0, 1.
    @(posedge clk); #1;
    set_req(1, 1'b0, 6'd2, 24'd0);
    set_req(0, 1'b0, 6'd5, 24'd0);
    req_valid = 2'b10; #1;
    chk("p1_ready", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b11; #1;
    chk("p2_ready", req_ready, 2'b01);
    chk("p2_addr", sram_addr, 5);
    chk("p2_rsp", rsp_valid, 2'b10);
    chk("p2_data", rsp_rdata, 24'h123456);
    @(posedge clk); #2;
    chk("p3_ready", req_ready, 2'b10);
    chk("p3_addr", sram_addr, 2);
    chk("p3_rsp", rsp_valid, 2'b01);
    chk("p3_data", rsp_rdata, 24'hABCDEF);
    @(posedge clk); #1;
    req_valid = 2'b00; #1;
    chk("p4_rsp", rsp_valid, 2'b10);
    chk("p4_data", rsp_rdata, 24'h123456);

    // Read accepted, then reset before the response edge.
    @(posedge clk); #1;
    set_req(0, 1'b0, 6'd5, 24'd0); req_valid = 2'b01; #1;
    chk("abort_ready", req_ready, 2'b01);
    #1; rst = 1'b1; #1;
    chk("abort_rst_ready", req_ready, 0);
    chk("abort_rst_we", sram_we, 0);
    chk("abort_rst_done", init_done, 0);
    chk("abort_rst_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    chk("abort_no_rsp", rsp_valid, 0);
    req_valid = 2'b00;
    @(negedge clk); rst = 1'b0;

    // Reset in the middle of INIT at init_cnt=20.
    run_init(20);
    #1; rst = 1'b1; #1;
    req_valid = 2'b00;
    chk("midinit_ready", req_ready, 0);
    chk("midinit_we", sram_we, 0);
    chk("midinit_done", init_done, 0);
    chk("midinit_rsp", rsp_valid, 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    run_init(63);
    @(posedge clk); #1;
    chk("reinit_done", init_done, 1);

    // Array was zero-filled again.
    set_req(0, 1'b0, 6'd5, 24'd0); req_valid = 2'b01; #1;
    chk("zf_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("zf_rsp", rsp_valid, 2'b01);
    chk("zf_data", rsp_rdata, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
